// File: rtl/mem_access_stage.sv
// MEM stage: decodes load/store width, runs one req/ack data-memory access at a
// time, aligns store lanes, extends load data and stalls the pipeline while busy.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    output logic [31:0] WriteData_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic              req_p1;
    logic              we_p1;
    logic [31:0]       addr_p1;
    logic [3:0]        be_p1;
    logic [31:0]       wdata_p1;
    logic [2:0]        funct3_p1;
    logic [1:0]        offset_p1;
    logic [CNT_W-1:0]  cnt_p1;

    logic              access;
    logic              illegal;
    logic              off_bad;
    logic              start;
    logic              timeout_hit;
    logic [3:0]        be_p0;
    logic [31:0]       wdata_p0;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend by width.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [31:0]        lane;
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        lane = rdata >> {off, 3'b000};
        b8   = lane[7:0];
        h16  = lane[15:0];
        case (f3)
            3'b000:  return 32'(b8);
            3'b001:  return 32'(h16);
            3'b100:  return {24'd0, lane[7:0]};
            3'b101:  return {16'd0, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    assign access = !bubble_i && (mem_read_i || mem_write_i);

    always_comb begin
        illegal  = 1'b0;
        off_bad  = 1'b0;
        be_p0    = 4'b0000;
        wdata_p0 = 32'd0;
        case (funct3_i[1:0])
            2'b00: begin
                be_p0    = 4'b0001 << addr_i[1:0];
                wdata_p0 = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_p0    = 4'b0011 << addr_i[1:0];
                wdata_p0 = {2{store_data_i[15:0]}};
                off_bad  = addr_i[0];
            end
            2'b10: begin
                be_p0    = 4'b1111;
                wdata_p0 = store_data_i;
                off_bad  = |addr_i[1:0];
                illegal  = funct3_i[2];
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants only exist for loads; a write always wins over a read.
        if (mem_write_i && funct3_i[2])
            illegal = 1'b1;
    end

    assign misalign_o  = access && (illegal || off_bad);
    assign start       = access && !misalign_o;
    assign timeout_hit = TO_EN && (cnt_p1 == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (dmem_ack_i || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_o     = 1'b0;
        bus_err_o   = 1'b0;
        WriteData_o = 32'd0;
        case (state)
            IDLE: stall_o = start;
            BUSY: begin
                stall_o   = !dmem_ack_i && !timeout_hit;
                bus_err_o = !dmem_ack_i && timeout_hit;
                if (dmem_ack_i && !we_p1)
                    WriteData_o = load_extend(funct3_p1, offset_p1, dmem_rdata_i);
            end
            default: ;
        endcase
        // The held EX_MEM instruction must not keep the pipeline frozen during reset.
        if (!reset)
            stall_o = 1'b0;
    end

    // Issue register: request fields stay frozen for the whole BUSY phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_p1    <= 1'b0;
            we_p1     <= 1'b0;
            addr_p1   <= 32'd0;
            be_p1     <= 4'b0000;
            wdata_p1  <= 32'd0;
            funct3_p1 <= 3'b000;
            offset_p1 <= 2'b00;
            cnt_p1    <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                req_p1    <= 1'b1;
                we_p1     <= mem_write_i;
                addr_p1   <= {addr_i[31:2], 2'b00};
                be_p1     <= be_p0;
                wdata_p1  <= wdata_p0;
                funct3_p1 <= funct3_i;
                offset_p1 <= addr_i[1:0];
                cnt_p1    <= '0;
            end
        end else begin
            if (dmem_ack_i || timeout_hit)
                req_p1 <= 1'b0;
            else
                cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign dmem_req_o   = req_p1;
    assign dmem_we_o    = we_p1;
    assign dmem_addr_o  = addr_p1;
    assign dmem_be_o    = be_p1;
    assign dmem_wdata_o = wdata_p1;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed accesses push expected bus
// requests and responses; a negedge monitor pops and compares them.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        bubble;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] rdata;
    logic        ack;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] WriteData_o;
    logic        stall_o;
    logic        misalign_o;
    logic        bus_err_o;

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bubble_i     (bubble),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .store_data_i (store_data),
        .dmem_rdata_i (rdata),
        .dmem_ack_i   (ack),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .WriteData_o  (WriteData_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] wd;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: new request -> compare bus fields; ack or bus error -> compare response.
    logic req_prev = 1'b0;
    req_t mon_r;
    rsp_t mon_e;
    always @(negedge clk) begin
        if (dmem_req_o && !req_prev) begin
            if (req_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_req: got addr 0x%08h, want no request", dmem_addr_o);
            end else begin
                mon_r = req_q.pop_front();
                chk("req_addr",  dmem_addr_o,         mon_r.addr);
                chk("req_we",    32'(dmem_we_o),      32'(mon_r.we));
                chk("req_be",    32'(dmem_be_o),      32'(mon_r.be));
                chk("req_wdata", dmem_wdata_o,        mon_r.wdata);
            end
        end
        if ((dmem_req_o && ack) || bus_err_o) begin
            if (rsp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got bus_err %0b, want no response", bus_err_o);
            end else begin
                mon_e = rsp_q.pop_front();
                chk("rsp_bus_err",   32'(bus_err_o), 32'(mon_e.err));
                chk("rsp_writedata", WriteData_o,    mon_e.wd);
            end
        end
        req_prev = dmem_req_o;
    end

    task automatic set_idle();
        bubble     = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'd0;
        store_data = 32'd0;
    endtask

    // ack_at: BUSY cycle index (0-based) carrying the ack; -1 = never (timeout).
    task automatic do_access(input string nm, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input int ack_at,
                             input logic [31:0] rd_data,
                             input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic [31:0] e_wdata, input logic [31:0] e_wd);
        req_t r;
        rsp_t e;
        logic done;
        r.addr  = e_addr;
        r.we    = wr;
        r.be    = e_be;
        r.wdata = e_wdata;
        req_q.push_back(r);
        e.err = (ack_at < 0);
        e.wd  = e_wd;
        rsp_q.push_back(e);
        @(posedge clk); #1;
        bubble = 1'b0; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; store_data = sd;
        @(negedge clk);
        chk({nm, "_stall_issue"}, 32'(stall_o), 32'd1);
        chk({nm, "_misalign"}, 32'(misalign_o), 32'd0);
        for (int k = 0; k < TO; k++) begin
            @(posedge clk); #1;
            if (k == ack_at) begin
                ack   = 1'b1;
                rdata = rd_data;
            end
            @(negedge clk);
            done = (k == ack_at) || (k == TO - 1);
            chk({nm, "_stall_busy"}, 32'(stall_o), done ? 32'd0 : 32'd1);
            chk({nm, "_addr_held"}, dmem_addr_o, e_addr);
            if (done) break;
        end
        @(posedge clk); #1;
        ack   = 1'b0;
        rdata = 32'd0;
        set_idle();
        @(negedge clk);
        chk({nm, "_req_dropped"}, 32'(dmem_req_o), 32'd0);
        chk({nm, "_stall_after"}, 32'(stall_o), 32'd0);
    endtask

    task automatic chk_mis(input string nm, input logic bub, input logic rd,
                           input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic exp_mis);
        @(posedge clk); #1;
        bubble = bub; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; store_data = 32'h0000_BEEF;
        @(negedge clk);
        chk({nm, "_misalign"}, 32'(misalign_o), 32'(exp_mis));
        chk({nm, "_stall"}, 32'(stall_o), 32'd0);
        chk({nm, "_writedata"}, WriteData_o, 32'd0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        chk({nm, "_no_req"}, 32'(dmem_req_o), 32'd0);
    endtask

    initial begin
        req_t rr;
        reset = 1'b0;
        ack   = 1'b0;
        rdata = 32'd0;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(dmem_req_o), 32'd0);
        chk("rst_we",    32'(dmem_we_o),  32'd0);
        chk("rst_addr",  dmem_addr_o,     32'd0);
        chk("rst_be",    32'(dmem_be_o),  32'd0);
        chk("rst_wdata", dmem_wdata_o,    32'd0);
        chk("rst_berr",  32'(bus_err_o),  32'd0);
        chk("rst_stall", 32'(stall_o),    32'd0);
        chk("rst_wd",    WriteData_o,     32'd0);
        #2 reset = 1'b1;

        do_access("lw",   1, 0, 3'b010, 32'h100, 32'd0, 2, 32'hDEADBEEF,
                  32'h100, 4'b1111, 32'd0, 32'hDEADBEEF);
        do_access("lb",   1, 0, 3'b000, 32'h203, 32'd0, 0, 32'h80123456,
                  32'h200, 4'b1000, 32'd0, 32'hFFFFFF80);
        do_access("lbu",  1, 0, 3'b100, 32'h203, 32'd0, 1, 32'h80123456,
                  32'h200, 4'b1000, 32'd0, 32'h00000080);
        do_access("lhu",  1, 0, 3'b101, 32'h202, 32'd0, 0, 32'h9ABC0000,
                  32'h200, 4'b1100, 32'd0, 32'h00009ABC);
        do_access("lh",   1, 0, 3'b001, 32'h106, 32'd0, 1, 32'h84210000,
                  32'h104, 4'b1100, 32'd0, 32'hFFFF8421);
        do_access("sb",   0, 1, 3'b000, 32'h301, 32'h000000A5, 1, 32'hFFFFFFFF,
                  32'h300, 4'b0010, 32'hA5A5A5A5, 32'd0);
        do_access("sh",   0, 1, 3'b001, 32'h302, 32'h00001234, 0, 32'hFFFFFFFF,
                  32'h300, 4'b1100, 32'h12341234, 32'd0);
        do_access("sw",   0, 1, 3'b010, 32'h40C, 32'hCAFEF00D, 0, 32'hFFFFFFFF,
                  32'h40C, 4'b1111, 32'hCAFEF00D, 32'd0);
        do_access("rdwr", 1, 1, 3'b000, 32'h501, 32'h0000005A, 0, 32'hFFFFFFFF,
                  32'h500, 4'b0010, 32'h5A5A5A5A, 32'd0);
        do_access("tmo",  1, 0, 3'b010, 32'h600, 32'd0, -1, 32'd0,
                  32'h600, 4'b1111, 32'd0, 32'd0);
        do_access("ackwin", 1, 0, 3'b010, 32'h604, 32'd0, TO - 1, 32'h13572468,
                  32'h604, 4'b1111, 32'd0, 32'h13572468);

        chk_mis("lw_mis",    0, 1, 0, 3'b010, 32'h102, 1'b1);
        chk_mis("sh_mis",    0, 0, 1, 3'b001, 32'h101, 1'b1);
        chk_mis("lw_bub",    1, 1, 0, 3'b010, 32'h102, 1'b0);
        chk_mis("sh_bub",    1, 0, 1, 3'b001, 32'h101, 1'b0);
        chk_mis("sbu_ill",   0, 0, 1, 3'b100, 32'h200, 1'b1);
        chk_mis("f3_011",    0, 1, 0, 3'b011, 32'h000, 1'b1);
        chk_mis("f3_110",    0, 1, 0, 3'b110, 32'h000, 1'b1);

        // Reset in the second BUSY cycle of a store, then a stray ack.
        rr.addr = 32'h704; rr.we = 1'b1; rr.be = 4'b1111; rr.wdata = 32'h11223344;
        req_q.push_back(rr);
        @(posedge clk); #1;
        bubble = 1'b0; mem_read = 1'b0; mem_write = 1'b1;
        funct3 = 3'b010; addr = 32'h704; store_data = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("arst_req",   32'(dmem_req_o), 32'd0);
        chk("arst_we",    32'(dmem_we_o),  32'd0);
        chk("arst_be",    32'(dmem_be_o),  32'd0);
        chk("arst_addr",  dmem_addr_o,     32'd0);
        chk("arst_stall", 32'(stall_o),    32'd0);
        set_idle();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        ack   = 1'b1;
        rdata = 32'h55AA55AA;
        @(negedge clk);
        chk("late_ack_wd",  WriteData_o,     32'd0);
        chk("late_ack_req", 32'(dmem_req_o), 32'd0);
        chk("late_ack_err", 32'(bus_err_o),  32'd0);
        @(posedge clk); #1;
        ack   = 1'b0;
        rdata = 32'd0;
        @(negedge clk);
        chk("late_ack_req2", 32'(dmem_req_o), 32'd0);

        repeat (3) @(posedge clk);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
